// File: rtl/instmem_v2.sv
// Instruction memory for the tinyGPU fetch path: synchronous-read RAM loaded
// through a streaming load port, read through a valid/ready fetch port.
module instmem_v2 #(
  parameter int                     INST_LENGTH = 8,
  parameter int                     ADDR_WIDTH  = 6,
  parameter logic [INST_LENGTH-1:0] NOP_INST    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_first,
  input  logic                   ld_last,
  input  logic [INST_LENGTH-1:0] ld_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   rsp_valid,
  output logic [INST_LENGTH-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   loading,
  output logic [ADDR_WIDTH:0]    prog_len,
  output logic                   load_ovf
);

  localparam int                  N     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(N);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]    prog_len_q, prog_len_d;
  logic                   load_ovf_q, load_ovf_d;
  logic                   rsp_valid_q;
  logic [INST_LENGTH-1:0] rsp_data_q;
  logic                   rsp_err_q;

  logic                   we;
  logic [ADDR_WIDTH-1:0]  waddr;
  logic                   accept;
  logic                   in_range;

  logic [INST_LENGTH-1:0] mem_q [N];

  // Load sequencing: an ld_first beat restarts from any state; other beats
  // only count while LOADING, and wptr saturates at N once the RAM is full.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    prog_len_d = prog_len_q;
    load_ovf_d = load_ovf_q;
    we         = 1'b0;
    waddr      = '0;
    if (ld_valid && ld_first) begin
      we         = 1'b1;
      wptr_d     = (ADDR_WIDTH + 1)'(1);
      load_ovf_d = 1'b0;
      if (ld_last) begin
        prog_len_d = (ADDR_WIDTH + 1)'(1);
        state_d    = READY;
      end else begin
        state_d = LOADING;
      end
    end else if (ld_valid && (state_q == LOADING)) begin
      if (wptr_q < DEPTH) begin
        we     = 1'b1;
        waddr  = wptr_q[ADDR_WIDTH-1:0];
        wptr_d = wptr_q + 1'b1;
      end else begin
        load_ovf_d = 1'b1;
      end
      if (ld_last) begin
        prog_len_d = (wptr_q == DEPTH) ? DEPTH : wptr_q + 1'b1;
        state_d    = READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      wptr_q     <= '0;
      prog_len_q <= '0;
      load_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      prog_len_q <= prog_len_d;
      load_ovf_q <= load_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= ld_data;
  end

  // Fetch reads the pre-edge RAM contents, so a colliding write to the same
  // address returns the old word.
  assign accept   = req_valid && (state_q == READY);
  assign in_range = {1'b0, req_addr} < prog_len_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_data_q <= in_range ? mem_q[req_addr] : NOP_INST;
        rsp_err_q  <= !in_range;
      end
    end
  end

  assign ld_ready  = 1'b1;
  assign req_ready = (state_q == READY);
  assign loading   = (state_q == LOADING);
  assign prog_len  = prog_len_q;
  assign load_ovf  = load_ovf_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instmem_v2.sv
// Scoreboard bench for instmem_v2: a reference model predicts every fetch
// response and the load-side status outputs.
module tb_instmem_v2;

  localparam int         IW  = 8;
  localparam int         AW  = 6;
  localparam int         N   = 2 ** AW;
  localparam logic [7:0] NOP = 8'hEE;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0, ld_first = 1'b0, ld_last = 1'b0;
  logic [IW-1:0] ld_data = '0;
  logic          req_valid = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          ld_ready, req_ready, rsp_valid, rsp_err, loading, load_ovf;
  logic [IW-1:0] rsp_data;
  logic [AW:0]   prog_len;

  instmem_v2 #(.INST_LENGTH(IW), .ADDR_WIDTH(AW), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_first(ld_first),
    .ld_last(ld_last), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .loading(loading), .prog_len(prog_len), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t exp_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic rst_d = 1'b0;
  logic armed = 1'b0;
  logic [7:0] last_d = '0;
  logic       last_e = 1'b0;

  // Reference model state
  logic [7:0] mem_m [N];
  int st_m = 0;  // 0 EMPTY, 1 LOADING, 2 READY
  int plen_m = 0;
  int wptr_m = 0;
  logic ovf_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  always @(negedge clk) begin
    if (armed) begin
      if (rst_d) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        last_d = '0;
        last_e = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        last_d = e.d;
        last_e = e.e;
      end else begin
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("hold_rsp_data", 32'(rsp_data), 32'(last_d));
        chk("hold_rsp_err", 32'(rsp_err), 32'(last_e));
      end
    end
  end

  task automatic step(input logic rst, input logic ldv, input logic ldf, input logic ldl,
                      input logic [7:0] ldd, input logic rqv, input logic [AW-1:0] ra);
    int w;
    reset = rst; ld_valid = ldv; ld_first = ldf; ld_last = ldl; ld_data = ldd;
    req_valid = rqv; req_addr = ra;
    if (armed) chk("req_ready", 32'(req_ready), 32'(st_m == 2));
    if (!rst && rqv && st_m == 2) begin
      exp_t e;
      e.due = cyc + 1;
      e.e   = !(int'(ra) < plen_m);
      e.d   = e.e ? NOP : mem_m[ra];
      exp_q.push_back(e);
    end
    if (rst) begin
      st_m = 0; plen_m = 0; wptr_m = 0; ovf_m = 1'b0;
    end else if (ldv && ldf) begin
      mem_m[0] = ldd; wptr_m = 1; ovf_m = 1'b0;
      if (ldl) begin plen_m = 1; st_m = 2; end
      else st_m = 1;
    end else if (ldv && st_m == 1) begin
      w = wptr_m;
      if (w < N) begin mem_m[w] = ldd; wptr_m = w + 1; end
      else ovf_m = 1'b1;
      if (ldl) begin plen_m = (w + 1 > N) ? N : w + 1; st_m = 2; end
    end
    @(posedge clk);
    #1;
    chk("prog_len", 32'(prog_len), 32'(plen_m));
    chk("load_ovf", 32'(load_ovf), 32'(ovf_m));
    chk("loading", 32'(loading), 32'(st_m == 1));
    chk("ld_ready", 32'(ld_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00, 0, '0);
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    step(0, 0, 0, 0, 8'h00, 1, a);
  endtask

  initial begin
    logic [7:0] four [4];
    four[0] = 8'hA1; four[1] = 8'hB2; four[2] = 8'hC3; four[3] = 8'hD4;

    // Reset then fetch attempt while EMPTY
    step(1, 0, 0, 0, 8'h00, 0, '0);
    armed = 1'b1;
    step(1, 0, 0, 0, 8'h00, 0, '0);
    step(0, 0, 0, 0, 8'h00, 1, '0);
    step(0, 0, 0, 0, 8'h00, 1, '0);
    idle(2);

    // Four-word program, back-to-back fetches 0..5
    for (int i = 0; i < 4; i++) step(0, 1, i == 0, i == 3, four[i], 0, '0);
    for (int i = 0; i < 6; i++) fetch(AW'(i));
    idle(2);

    // Overflow: N+3 words, the last three are dropped
    for (int i = 0; i < N + 3; i++)
      step(0, 1, i == 0, i == N + 2, 8'((i * 7 + 3) ^ 8'h5C), 0, '0);
    fetch(AW'(N - 1));
    fetch(AW'(N - 2));
    fetch('0);
    idle(1);

    // Single-beat program also clears load_ovf
    step(0, 1, 1, 1, 8'h5A, 0, '0);
    fetch('0);
    fetch(AW'(1));
    idle(2);

    // Reload collision: fetch of address 0 alongside a new ld_first beat
    step(0, 1, 1, 0, 8'h11, 0, '0);
    step(0, 1, 0, 1, 8'h33, 0, '0);
    step(0, 1, 1, 0, 8'h22, 1, '0);
    step(0, 0, 0, 0, 8'h00, 1, '0);
    step(0, 1, 0, 1, 8'h44, 1, '0);
    fetch('0);
    fetch(AW'(1));
    fetch(AW'(2));
    idle(2);

    // Reset after the second beat, then stray beats while EMPTY
    step(0, 1, 1, 0, 8'h66, 0, '0);
    step(0, 1, 0, 0, 8'h67, 0, '0);
    step(1, 0, 0, 0, 8'h00, 0, '0);
    step(0, 1, 0, 0, 8'h68, 1, '0);
    step(0, 1, 0, 1, 8'h69, 1, '0);
    idle(1);

    // Stray beats while READY leave the program untouched
    step(0, 1, 1, 1, 8'h77, 0, '0);
    step(0, 1, 0, 1, 8'h78, 0, '0);
    step(0, 1, 0, 0, 8'h79, 1, AW'(1));
    fetch('0);
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/instmem_v2.md
# instmem_v2

Parametrised instruction memory for the tinyGPU fetch path. It replaces the fixed, file-initialised asynchronous ROM with a synchronous-read RAM. The RAM is loaded at run time through a sequential streaming load port, and a fetch port sits behind a valid/ready handshake. It tracks program length, returns a configurable NOP plus an error flag for fetches past the end of the loaded program, and blocks fetches while a load is in progress.

## Interface
- `INST_LENGTH`, default 8: instruction width in bits.
- `ADDR_WIDTH`, default 6: fetch address width. Depth is N = 2**ADDR_WIDTH.
- `NOP_INST`, default 0: value returned on out-of-range fetch.

- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `ld_valid`  in  1: load beat present.
- `ld_ready`  out  1: load beat can be taken. Constant 1 (loads never stall).
- `ld_first`  in  1: beat is the first word of a new program.
- `ld_last`  in  1: beat is the final word of the program.
- `ld_data`  in  INST_LENGTH: instruction word.
- `req_valid`  in  1: fetch request.
- `req_ready`  out  1: fetch can be accepted. Equals 1 exactly when state is READY.
- `req_addr`  in  ADDR_WIDTH: fetch address.
- `rsp_valid`  out  1: fetch response valid.
- `rsp_data`  out  INST_LENGTH: fetched instruction, or NOP_INST.
- `rsp_err`  out  1: fetch address ≥ `prog_len`.
- `loading`  out  1: state is LOADING.
- `prog_len`  out  ADDR_WIDTH+1: number of valid words, 0..N.
- `load_ovf`  out  1: sticky; last load exceeded N words.

## Operation
- **States:** EMPTY, LOADING, READY.
- **Reset:**
  - state = EMPTY.
  - `prog_len`, `rsp_valid`, `rsp_err`, `load_ovf` = 0; `rsp_data` = 0.
  - Write pointer `wptr` = 0.
  - RAM contents are not cleared.
- **Load beat:** a beat is taken when `ld_valid`=1, since `ld_ready` is always 1.
  - **First beat, any state:** a beat with `ld_first`=1 in any state starts a new program.
    - Writes `ld_data` to address 0.
    - Sets `wptr`=1 and clears `load_ovf`.
    - State becomes LOADING.
    - If `ld_last`=1 as well, the load finishes in the same beat: `prog_len`=1 and state becomes READY.
  - **Subsequent beats, LOADING:** a beat with `ld_first`=0 in LOADING writes to address `wptr` (when `wptr`<N) and increments `wptr`.
  - **Overflow:** if `wptr`=N, the word is dropped and `load_ovf` is set. `wptr` saturates at N.
  - **Completing the load:** a beat with `ld_last`=1 in LOADING sets `prog_len` = min(`wptr`+1, N) and state becomes READY. The last word itself is written if it fits.
  - **Stray beats:** a beat with `ld_first`=0 in EMPTY or READY is dropped silently. It changes no state and no flags.
- **Fetch:** a fetch is accepted when `req_valid` && `req_ready`.
  - The cycle after acceptance, `rsp_valid`=1.
  - **In range** (`req_addr` < `prog_len`): `rsp_data` = RAM[`req_addr`] and `rsp_err`=0.
  - **Out of range:** `rsp_data` = NOP_INST and `rsp_err`=1.
  - The comparison is unsigned at ADDR_WIDTH+1 bits.
  - **Hold when idle:** with no accepted request, `rsp_valid`=0 while `rsp_data` and `rsp_err` keep their last values.
  - **EMPTY and LOADING:** `req_ready`=0 and requests are ignored. No response is generated.
- **Simultaneous events:**
  - A fetch accepted in READY in the same cycle as an `ld_first` beat completes normally.
  - Its range check uses the pre-load `prog_len`.
  - Its data is read-before-write, so address 0 returns the old word.
  - The next cycle, state is LOADING and `req_ready`=0.
- **Reset mid-load:** the load is abandoned; state becomes EMPTY and `prog_len`=0. Words already written stay in the RAM but are unreachable until a new load completes.

## Timing
- Load write takes effect on the accepting edge. The load port has zero-cycle backpressure.
- Load completion:
  - `prog_len`, state and `loading` update on the edge that takes the `ld_last` beat.
  - `req_ready`=1 from the next cycle.
- Fetch latency is exactly 1 cycle, request to `rsp_valid`. Throughput is 1 fetch per cycle in READY.
- A write at cycle t is visible to a fetch accepted at cycle t+1 or later.
- All outputs are registered, except `req_ready` and `ld_ready`, which are decoded from state.

## Test plan
- **Reset then fetch:** assert `reset` for 2 cycles, then `req_valid`=1 with `req_addr`=0.
  - Required: `req_ready`=0, `rsp_valid` stays 0, `prog_len`=0.
- **Load and read back:** load 4 beats 0xA1, 0xB2, 0xC3, 0xD4 (first beat `ld_first`, last beat `ld_last`), then fetch addresses 0..5 back-to-back.
  - Addresses 0..3 return 0xA1..0xD4 with `rsp_err`=0, each 1 cycle after its request.
  - Addresses 4 and 5 return NOP_INST with `rsp_err`=1.
  - `prog_len`=4.
- **Overflow:** load N+3 words.
  - `prog_len`=N and `load_ovf`=1.
  - Address N-1 holds word N-1; the dropped words are never visible.
  - Starting a new load clears `load_ovf`.
- **Single-beat program:** one beat with `ld_first`=`ld_last`=1 and data 0x5A.
  - `prog_len`=1 and READY on the next cycle.
  - Address 0 returns 0x5A; address 1 returns NOP_INST with `rsp_err`=1.
- **Reload collision:** in READY with old RAM[0]=0x11, fetch address 0 in the same cycle as an `ld_first` beat with 0x22.
  - The response is 0x11 with `rsp_err`=0.
  - `req_ready`=0 from the next cycle until `ld_last`.
  - A later fetch of address 0 returns 0x22.
- **Reset mid-load and stray beats:** assert `reset` after the 2nd beat of a load.
  - State is EMPTY and `prog_len`=0.
  - Subsequent beats with `ld_first`=0 are dropped, with no change to state or flags.
